pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//   Generic pipeline-boundary register slice for the pipeline_top IF->ID, EXE->LSU and LSU->WRB stage boundaries.
//   Replaces the hand-written stall/flush pipe_ff blocks with one parametrised slice.
//   Adds a valid/ready handshake and an optional 2-entry skid buffer, so back-pressure does not
//   create a combinational ready path across stages. Flush inserts a bubble carrying FLUSH_DATA and a sticky flushed flag.
// PARAMETERS
//   DATA_W      64             width of data payload (pc, instr, operands...)
//   CTRL_W      8              width of control payload; forced to zero in bubbles
//   RST_DATA    '0 (DATA_W)    data value held after reset (e.g. NOP instr 32'h00000013 in low bits)
//   FLUSH_DATA  '0 (DATA_W)    data value loaded on flush
//   SKID_EN     1              1: two entries, registered up_ready_o; 0: single entry, pass-through ready
// PORTS
//   clk           in   1       clock
//   rst_n         in   1       synchronous active-low reset
//   up_valid_i    in   1       upstream entry valid
//   up_ready_o    out  1       slice can accept an entry this cycle
//   up_data_i     in   DATA_W  upstream data
//   up_ctrl_i     in   CTRL_W  upstream control
//   stall_i       in   1       freeze slice (from forward_stall)
//   flush_i       in   1       kill all held entries (from forward_stall)
//   dn_valid_o    out  1       output entry valid
//   dn_ready_i    in   1       downstream accepts output
//   dn_data_o     out  DATA_W  output data
//   dn_ctrl_o     out  CTRL_W  output control, '0 when dn_valid_o=0
//   dn_flushed_o  out  1       output slot holds a flush bubble
//   occupancy_o   out  2       entries held: 0, 1 or 2
// BEHAVIOUR
//   Reset: valid/skid cleared, dn_data_o=RST_DATA, dn_ctrl_o=0, dn_flushed_o=0, occupancy_o=0.
//   up_ready_o=1 in the first cycle after reset unless stall_i/flush_i.
//   up_fire = up_valid_i & up_ready_o.  dn_fire = dn_valid_o & dn_ready_i & ~stall_i & ~flush_i.
//   dn_valid_o = main_valid; dn_data_o = main_data; dn_ctrl_o = main_valid ? main_ctrl : '0.
//   up_ready_o: SKID_EN=1 -> ~skid_valid & ~stall_i & ~flush_i (state-only except stall/flush).
//               SKID_EN=0 -> ~stall_i & ~flush_i & (~main_valid | dn_ready_i).
//   States (occupancy): EMPTY(0), ONE(1), TWO(2, SKID_EN=1 only). Latency in->out: 1 cycle.
//     EMPTY: up_fire -> ONE, main<=up.
//     ONE:   up_fire&dn_fire -> ONE, main<=up; up_fire&~dn_fire -> TWO, skid<=up (SKID_EN=1 only).
//            ~up_fire&dn_fire -> EMPTY.
//     TWO:   dn_fire -> ONE, main<=skid; no upstream accept (up_ready_o=0).
//   SKID_EN=0: ONE&up_fire implies dn_fire (ready is pass-through), so TWO is unreachable.
//   stall_i=1 and flush_i=0: all state held, no fires; outputs stable.
//   flush_i=1: highest priority over stall, handshakes and any input. Next state EMPTY, skid dropped,
//     main_data<=FLUSH_DATA, main_ctrl<=0, dn_flushed_o<=1.
//     Input presented in the flush cycle is dropped because up_ready_o=0.
//   dn_flushed_o: cleared when a new entry loads main (up_fire into EMPTY, or ONE/TWO reload).
//   Stability: while dn_valid_o & ~dn_fire, dn_data_o/dn_ctrl_o do not change.
//   Order is FIFO; no entry lost or duplicated. No wrap: occupancy saturates at 2 by ready gating.
//   rst_n low mid-operation: all entries discarded, reset values on next edge.
// TESTING
//   1 Reset: hold rst_n=0 2 cycles with up_valid_i=1, RST_DATA=0x13
//     -> dn_valid_o=0, dn_data_o=0x13, dn_ctrl_o=0, occ=0; up_ready_o=1 after release.
//   2 Stream: dn_ready_i=1, push A,B,C back-to-back -> A,B,C on dn one cycle later each, 1/cycle, occ=1.
//   3 Skid: dn_ready_i=0, push A,B -> occ=2, up_ready_o=0 on cycle 3;
//     dn_ready_i=1 -> A then B, up_ready_o=1 one cycle after A leaves.
//   4 Stall: occ=1 (A), stall_i=1, dn_ready_i=1, up_valid_i=1 (B) for 3 cycles
//     -> dn_data_o=A held, up_ready_o=0, no B accepted.
//   5 Flush: occ=2, flush_i=1 with stall_i=1, up_valid_i=1 (C) -> next cycle dn_valid_o=0,
//     dn_data_o=FLUSH_DATA, dn_flushed_o=1, occ=0; next accepted D clears dn_flushed_o.
//   6 SKID_EN=0: main full, dn_ready_i=0 -> up_ready_o=0 same cycle;
//     dn_ready_i=1 -> A out, B in same edge, occ stays 1.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: pipeline-boundary register slice with valid/ready handshake,
// stall/flush control and an optional second (skid) entry. With the skid entry
// enabled, up_ready_o depends only on held state plus stall/flush, which breaks
// the combinational ready chain between stages.
module pipe_stage_buf #(
   parameter int unsigned       DATA_W     = 64,
   parameter int unsigned       CTRL_W     = 8,
   parameter logic [DATA_W-1:0] RST_DATA   = '0,
   parameter logic [DATA_W-1:0] FLUSH_DATA = '0,
   parameter bit                SKID_EN    = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              up_valid_i,
   output logic              up_ready_o,
   input  logic [DATA_W-1:0] up_data_i,
   input  logic [CTRL_W-1:0] up_ctrl_i,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              dn_valid_o,
   input  logic              dn_ready_i,
   output logic [DATA_W-1:0] dn_data_o,
   output logic [CTRL_W-1:0] dn_ctrl_o,
   output logic              dn_flushed_o,
   output logic [1:0]        occupancy_o
);

   // State encoding doubles as the occupancy count.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic              flushed_q, flushed_d;

   logic main_valid;
   logic skid_valid;
   logic up_fire;
   logic dn_fire;

   assign main_valid = (state_q != ST_EMPTY);
   assign skid_valid = (state_q == ST_TWO);

   // Ready: registered-style (skid) or pass-through (single entry).
   generate
      if (SKID_EN) begin : g_skid_ready
         assign up_ready_o = ~skid_valid & ~stall_i & ~flush_i;
      end else begin : g_pass_ready
         assign up_ready_o = ~stall_i & ~flush_i & (~main_valid | dn_ready_i);
      end
   endgenerate

   assign up_fire = up_valid_i & up_ready_o;
   assign dn_fire = main_valid & dn_ready_i & ~stall_i & ~flush_i;

   assign dn_valid_o   = main_valid;
   assign dn_data_o    = main_data_q;
   assign dn_ctrl_o    = main_valid ? main_ctrl_q : '0;
   assign dn_flushed_o = flushed_q;
   assign occupancy_o  = state_q;

   // Next-state: flush wins; stall needs no branch since it already blocks both fires.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      flushed_d   = flushed_q;
      if (flush_i) begin
         state_d     = ST_EMPTY;
         main_data_d = FLUSH_DATA;
         main_ctrl_d = '0;
         flushed_d   = 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (up_fire) begin
                  state_d     = ST_ONE;
                  main_data_d = up_data_i;
                  main_ctrl_d = up_ctrl_i;
                  flushed_d   = 1'b0;
               end
            end
            ST_ONE: begin
               if (up_fire && dn_fire) begin
                  main_data_d = up_data_i;
                  main_ctrl_d = up_ctrl_i;
                  flushed_d   = 1'b0;
               end else if (up_fire) begin
                  // Only reachable with the skid entry; pass-through ready
                  // guarantees dn_fire whenever up_fire hits a full slot.
                  if (SKID_EN) begin
                     state_d     = ST_TWO;
                     skid_data_d = up_data_i;
                     skid_ctrl_d = up_ctrl_i;
                  end
               end else if (dn_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (dn_fire) begin
                  state_d     = ST_ONE;
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  flushed_d   = 1'b0;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         main_data_q <= RST_DATA;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         flushed_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         flushed_q   <= flushed_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed stimulus for a skid-enabled slice (dut) and a
// single-entry slice (dut0); monitors pop expected entries on each dn handshake.
module tb_pipe_stage_buf;

   localparam int DW = 16;
   localparam int CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   // skid-enabled instance
   logic          v, st, fl, dr;
   logic [DW-1:0] d;
   logic [CW-1:0] c;
   logic          ur, dv, df;
   logic [DW-1:0] dd;
   logic [CW-1:0] dc;
   logic [1:0]    occ;
   // single-entry instance
   logic          v0, st0, fl0, dr0;
   logic [DW-1:0] d0;
   logic [CW-1:0] c0;
   logic          ur0, dv0, df0;
   logic [DW-1:0] dd0;
   logic [CW-1:0] dc0;
   logic [1:0]    occ0;

   logic [DW+CW-1:0] exp_q[$];
   logic [DW+CW-1:0] exp0_q[$];

   int total = 0;
   int bad   = 0;

   pipe_stage_buf #(
      .DATA_W(DW), .CTRL_W(CW), .RST_DATA(16'h0013), .FLUSH_DATA(16'hF1F1), .SKID_EN(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .up_valid_i(v), .up_ready_o(ur), .up_data_i(d), .up_ctrl_i(c),
      .stall_i(st), .flush_i(fl),
      .dn_valid_o(dv), .dn_ready_i(dr), .dn_data_o(dd), .dn_ctrl_o(dc),
      .dn_flushed_o(df), .occupancy_o(occ)
   );

   pipe_stage_buf #(
      .DATA_W(DW), .CTRL_W(CW), .RST_DATA(16'h0013), .FLUSH_DATA(16'hF1F1), .SKID_EN(1'b0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n),
      .up_valid_i(v0), .up_ready_o(ur0), .up_data_i(d0), .up_ctrl_i(c0),
      .stall_i(st0), .flush_i(fl0),
      .dn_valid_o(dv0), .dn_ready_i(dr0), .dn_data_o(dd0), .dn_ctrl_o(dc0),
      .dn_flushed_o(df0), .occupancy_o(occ0)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Monitor for the skid instance: one pop per downstream handshake.
   task automatic mon1();
      logic [DW+CW-1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && dv && dr && !st && !fl) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL mon_skid_extra: got data=%h ctrl=%h required no output", dd, dc);
            end else begin
               e = exp_q.pop_front();
               if ({dd, dc} !== e) begin
                  bad++;
                  $display("FAIL mon_skid_data: got %h/%h required %h/%h",
                           dd, dc, e[DW+CW-1:CW], e[CW-1:0]);
               end else begin
                  $display("skid out data=%h ctrl=%h", dd, dc);
               end
            end
         end
      end
   endtask

   // Monitor for the single-entry instance.
   task automatic mon0();
      logic [DW+CW-1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && dv0 && dr0 && !st0 && !fl0) begin
            total++;
            if (exp0_q.size() == 0) begin
               bad++;
               $display("FAIL mon_pass_extra: got data=%h ctrl=%h required no output", dd0, dc0);
            end else begin
               e = exp0_q.pop_front();
               if ({dd0, dc0} !== e) begin
                  bad++;
                  $display("FAIL mon_pass_data: got %h/%h required %h/%h",
                           dd0, dc0, e[DW+CW-1:CW], e[CW-1:0]);
               end else begin
                  $display("pass out data=%h ctrl=%h", dd0, dc0);
               end
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      v = 1'b1; d = 16'h0055; c = 4'h1; st = 1'b0; fl = 1'b0; dr = 1'b0;
      v0 = 1'b1; d0 = 16'h0055; c0 = 4'h1; st0 = 1'b0; fl0 = 1'b0; dr0 = 1'b0;
      fork
         mon1();
         mon0();
      join_none

      // 1: reset held two cycles with valid input present
      cyc(); cyc();
      mid();
      chk("rst_dv", {31'd0, dv}, 32'd0);
      chk("rst_dd", {16'd0, dd}, 32'h13);
      chk("rst_dc", {28'd0, dc}, 32'd0);
      chk("rst_occ", {30'd0, occ}, 32'd0);
      chk("rst_df", {31'd0, df}, 32'd0);
      chk("rst_occ0", {30'd0, occ0}, 32'd0);
      chk("rst_dd0", {16'd0, dd0}, 32'h13);
      cyc(); rst_n = 1'b1; v = 1'b0; v0 = 1'b0;
      mid();
      chk("rst_ur", {31'd0, ur}, 32'd1);
      chk("rst_ur0", {31'd0, ur0}, 32'd1);

      // 2: back-to-back stream with downstream always ready
      cyc(); dr = 1'b1; v = 1'b1; d = 16'h00A1; c = 4'h1; exp_q.push_back({16'h00A1, 4'h1});
      mid(); chk("str_ur", {31'd0, ur}, 32'd1);
      cyc(); d = 16'h00A2; c = 4'h2; exp_q.push_back({16'h00A2, 4'h2});
      mid(); chk("str_dv", {31'd0, dv}, 32'd1); chk("str_occ_a", {30'd0, occ}, 32'd1);
      cyc(); d = 16'h00A3; c = 4'h3; exp_q.push_back({16'h00A3, 4'h3});
      mid(); chk("str_occ_b", {30'd0, occ}, 32'd1);
      cyc(); v = 1'b0;
      mid(); chk("str_occ_c", {30'd0, occ}, 32'd1);
      cyc();
      mid(); chk("str_occ_end", {30'd0, occ}, 32'd0);

      // 3: skid fill with downstream blocked, then drain
      cyc(); dr = 1'b0; v = 1'b1; d = 16'h00B1; c = 4'h4; exp_q.push_back({16'h00B1, 4'h4});
      mid(); chk("skid_ur1", {31'd0, ur}, 32'd1);
      cyc(); d = 16'h00B2; c = 4'h5; exp_q.push_back({16'h00B2, 4'h5});
      mid(); chk("skid_ur2", {31'd0, ur}, 32'd1);
      cyc(); v = 1'b0;
      mid();
      chk("skid_occ2", {30'd0, occ}, 32'd2);
      chk("skid_ur3", {31'd0, ur}, 32'd0);
      chk("skid_dd", {16'd0, dd}, 32'h00B1);
      cyc(); dr = 1'b1;
      mid(); chk("skid_ur_drain", {31'd0, ur}, 32'd0);
      cyc();
      mid(); chk("skid_ur_after", {31'd0, ur}, 32'd1); chk("skid_occ1", {30'd0, occ}, 32'd1);
      cyc(); dr = 1'b0;
      mid(); chk("skid_occ0", {30'd0, occ}, 32'd0);

      // 4: stall holds the slot and refuses upstream
      cyc(); v = 1'b1; d = 16'h00C1; c = 4'h6; exp_q.push_back({16'h00C1, 4'h6});
      mid();
      cyc(); st = 1'b1; dr = 1'b1; v = 1'b1; d = 16'h0BAD; c = 4'hF;
      for (int i = 0; i < 3; i++) begin
         mid();
         chk("stall_dd", {16'd0, dd}, 32'h00C1);
         chk("stall_ur", {31'd0, ur}, 32'd0);
         chk("stall_occ", {30'd0, occ}, 32'd1);
         chk("stall_dv", {31'd0, dv}, 32'd1);
         cyc();
      end
      st = 1'b0; v = 1'b0;
      mid();
      cyc();
      mid(); chk("stall_occ_end", {30'd0, occ}, 32'd0);

      // 5: flush with stall and input both active
      cyc(); dr = 1'b0; v = 1'b1; d = 16'h00D1; c = 4'h7; exp_q.push_back({16'h00D1, 4'h7});
      mid();
      cyc(); d = 16'h00D2; c = 4'h8; exp_q.push_back({16'h00D2, 4'h8});
      mid();
      cyc(); v = 1'b0;
      mid(); chk("fl_pre_occ", {30'd0, occ}, 32'd2);
      cyc(); fl = 1'b1; st = 1'b1; v = 1'b1; d = 16'h0CCC; c = 4'hA;
      mid(); chk("fl_ur", {31'd0, ur}, 32'd0);
      cyc(); exp_q.delete(); fl = 1'b0; st = 1'b0; v = 1'b0;
      mid();
      chk("fl_dv", {31'd0, dv}, 32'd0);
      chk("fl_dd", {16'd0, dd}, 32'hF1F1);
      chk("fl_df", {31'd0, df}, 32'd1);
      chk("fl_occ", {30'd0, occ}, 32'd0);
      chk("fl_dc", {28'd0, dc}, 32'd0);
      cyc(); v = 1'b1; d = 16'h00E1; c = 4'h9; exp_q.push_back({16'h00E1, 4'h9});
      mid(); chk("fl_df_hold", {31'd0, df}, 32'd1);
      cyc(); v = 1'b0;
      mid();
      chk("fl_df_clr", {31'd0, df}, 32'd0);
      chk("fl_occ_d", {30'd0, occ}, 32'd1);
      chk("fl_dd_d", {16'd0, dd}, 32'h00E1);
      cyc(); dr = 1'b1;
      mid();
      cyc(); dr = 1'b0;
      mid(); chk("fl_occ_end", {30'd0, occ}, 32'd0);

      // 6: single-entry slice, pass-through ready
      cyc(); dr0 = 1'b0; v0 = 1'b1; d0 = 16'h0061; c0 = 4'h1; exp0_q.push_back({16'h0061, 4'h1});
      mid();
      cyc(); d0 = 16'h0062; c0 = 4'h2;
      mid(); chk("pass_ur_blk", {31'd0, ur0}, 32'd0);
      cyc(); dr0 = 1'b1; exp0_q.push_back({16'h0062, 4'h2});
      mid(); chk("pass_ur_go", {31'd0, ur0}, 32'd1);
      cyc(); v0 = 1'b0;
      mid();
      chk("pass_occ1", {30'd0, occ0}, 32'd1);
      chk("pass_dd", {16'd0, dd0}, 32'h0062);
      cyc();
      mid(); chk("pass_occ0", {30'd0, occ0}, 32'd0);
      cyc(); dr0 = 1'b0;

      // nothing expected may remain outstanding
      cyc(); cyc();
      chk("skid_q_empty", exp_q.size(), 32'd0);
      chk("pass_q_empty", exp0_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
